// File: rtl/iob_timer_reader_pkg.sv
// Shared types and defaults for the iob_timer_reader timestamp initiator.
package iob_timer_reader_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [DEF_ADDR_W-1:0] DEF_SAMPLE_ADDR = 4'h2;
  localparam logic [DEF_ADDR_W-1:0] DEF_DLOW_ADDR   = 4'h4;
  localparam logic [DEF_ADDR_W-1:0] DEF_DHIGH_ADDR  = 4'h8;

  localparam logic [DEF_DATA_W/8-1:0] WSTRB_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_S_SET    = 3'd1,
    ST_S_CLR    = 3'd2,
    ST_RLO_REQ  = 3'd3,
    ST_RLO_WAIT = 3'd4,
    ST_RHI_REQ  = 3'd5,
    ST_RHI_WAIT = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_REQ  = 2'd1,
    X_WAIT = 2'd2
  } xfer_e;

endpackage

// File: rtl/iob_timer_reader_if.sv
// Point-to-point IOb request/response bundle between initiator and timer.
interface iob_timer_reader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) ();

  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (
    output avalid, addr, wdata, wstrb,
    input  rvalid, rdata, ready
  );

  modport slave (
    input  avalid, addr, wdata, wstrb,
    output rvalid, rdata, ready
  );

endinterface

// File: rtl/iob_timer_reader_xfer.sv
// Single-transaction IOb master: holds the request until accepted, then
// waits for rvalid on reads. A go on the completing cycle chains the next one.
module iob_timer_reader_xfer
  import iob_timer_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                go_i,
  input  logic                is_read_i,
  input  logic                abort_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                accept_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  iob_timer_reader_if.master  iob
);

  xfer_e                phase_q, phase_d;
  logic                 is_read_q, is_read_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W/8-1:0]  wstrb_q, wstrb_d;

  always_comb begin
    phase_d   = phase_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    accept_o  = (phase_q == X_REQ) && iob.ready && !abort_i;
    done_o    = (accept_o && !is_read_q) ||
                ((phase_q == X_WAIT) && iob.rvalid && !abort_i);

    if (abort_i) begin
      phase_d = X_IDLE;
    end else if (go_i) begin
      // Request fields are captured here and frozen until acceptance.
      phase_d   = X_REQ;
      is_read_d = is_read_i;
      addr_d    = addr_i;
      wdata_d   = wdata_i;
      wstrb_d   = is_read_i ? '0 : '1;
    end else begin
      case (phase_q)
        X_REQ:   if (iob.ready)  phase_d = is_read_q ? X_WAIT : X_IDLE;
        X_WAIT:  if (iob.rvalid) phase_d = X_IDLE;
        default: phase_d = X_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      phase_q   <= X_IDLE;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (cke_i) begin
      phase_q   <= phase_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // The timeout abort may withdraw a request that was never accepted.
  assign iob.avalid = (phase_q == X_REQ) && !abort_i;
  assign iob.addr   = addr_q;
  assign iob.wdata  = wdata_q;
  assign iob.wstrb  = wstrb_q;
  assign rdata_o    = iob.rdata;

endmodule

// File: rtl/iob_timer_reader.sv
// Captures a coherent {DATA_HIGH, DATA_LOW} timestamp from an iob_timer.
// Optional per-state timeout enabled by IOB_TIMER_READER_TIMEOUT_EN.
module iob_timer_reader
  import iob_timer_reader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] SAMPLE_ADDR = ADDR_W'(DEF_SAMPLE_ADDR),
  parameter logic [ADDR_W-1:0] DLOW_ADDR   = ADDR_W'(DEF_DLOW_ADDR),
  parameter logic [ADDR_W-1:0] DHIGH_ADDR  = ADDR_W'(DEF_DHIGH_ADDR)
`ifdef IOB_TIMER_READER_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT_CYC = 255
`endif
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 ts_valid_o,
  output logic [2*DATA_W-1:0]  ts_o,
  output logic                 err_o,
  iob_timer_reader_if.master   iob
);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    lo_q, lo_d;
  logic [2*DATA_W-1:0]  ts_q, ts_d;
  logic                 ts_valid_q, ts_valid_d;

  logic                 x_go;
  logic                 x_is_read;
  logic [ADDR_W-1:0]    x_addr;
  logic [DATA_W-1:0]    x_wdata;
  logic                 x_accept;
  logic                 x_done;
  logic [DATA_W-1:0]    x_rdata;
  logic                 timeout;

  iob_timer_reader_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .cke_i     (cke_i),
    .go_i      (x_go),
    .is_read_i (x_is_read),
    .abort_i   (timeout),
    .addr_i    (x_addr),
    .wdata_i   (x_wdata),
    .accept_o  (x_accept),
    .done_o    (x_done),
    .rdata_o   (x_rdata),
    .iob       (iob)
  );

  // Each step launches the next transfer on the cycle the current one completes.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    ts_d       = ts_q;
    ts_valid_d = 1'b0;
    x_go       = 1'b0;
    x_is_read  = 1'b0;
    x_addr     = SAMPLE_ADDR;
    x_wdata    = '0;

    if (timeout) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_d = ST_S_SET;
          x_go    = 1'b1;
          x_wdata = DATA_W'(1);
        end
        ST_S_SET: if (x_accept) begin
          state_d = ST_S_CLR;
          x_go    = 1'b1;
        end
        ST_S_CLR: if (x_accept) begin
          state_d   = ST_RLO_REQ;
          x_go      = 1'b1;
          x_is_read = 1'b1;
          x_addr    = DLOW_ADDR;
        end
        ST_RLO_REQ: if (x_accept) state_d = ST_RLO_WAIT;
        ST_RLO_WAIT: if (x_done) begin
          lo_d      = x_rdata;
          state_d   = ST_RHI_REQ;
          x_go      = 1'b1;
          x_is_read = 1'b1;
          x_addr    = DHIGH_ADDR;
        end
        ST_RHI_REQ: if (x_accept) state_d = ST_RHI_WAIT;
        ST_RHI_WAIT: if (x_done) begin
          ts_d       = {x_rdata, lo_q};
          ts_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      lo_q       <= '0;
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      ts_q       <= ts_d;
      ts_valid_q <= ts_valid_d;
    end
  end

`ifdef IOB_TIMER_READER_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  // Counter restarts on every state entry so each wait gets the full budget.
  assign timeout = (state_q != ST_IDLE) && (tcnt_q == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    tcnt_d = tcnt_q + 1'b1;
    if ((state_q == ST_IDLE) || (state_d != state_q)) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tcnt_q <= '0;
    end else if (cke_i) begin
      tcnt_q <= tcnt_d;
    end
  end

  assign err_o = timeout;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign busy_o     = (state_q != ST_IDLE);
  assign ts_valid_o = ts_valid_q;
  assign ts_o       = ts_q;

endmodule

// File: tb/tb_iob_timer_reader.sv
// Bench for iob_timer_reader: table vectors, randomized captures and
// hand-written reset/back-to-back/timeout sequences against a reactive timer model.
module tb_iob_timer_reader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cke;
  logic        start;
  logic        busy;
  logic        ts_valid;
  logic [63:0] ts;
  logic        err;

  always #5 clk = ~clk;

  iob_timer_reader_if #(.ADDR_W(4), .DATA_W(32)) iob ();

  iob_timer_reader #(
    .ADDR_W (4),
    .DATA_W (32)
`ifdef IOB_TIMER_READER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .cke_i      (cke),
    .start_i    (start),
    .busy_o     (busy),
    .ts_valid_o (ts_valid),
    .ts_o       (ts),
    .err_o      (err),
    .iob        (iob)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Timer target model: programmable ready stall and rvalid delay.
  int          cfg_stall = 0;
  int          cfg_d     = 1;
  logic [31:0] tmr_lo = '0, tmr_hi = '0;
  logic        ready_r = 1'b0;
  logic        rv_model = 1'b0;
  logic [31:0] rd_model = '0;
  logic        rv_inject = 1'b0;
  logic [31:0] inj_data = '0;
  int          wait_cnt = 0;
  int          rd_cd = 0;
  logic [3:0]  rd_addr = '0;
  bit          prev_pend = 0;
  logic [3:0]  p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;
  int          viol = 0;
  logic [36:0] log_q[$];
  int          tv_cnt = 0;
  int          err_cnt = 0;

  assign iob.ready  = ready_r;
  assign iob.rvalid = rv_model | rv_inject;
  assign iob.rdata  = rv_inject ? inj_data : rd_model;

  always @(negedge clk) begin
    if (!arst_n) begin
      wait_cnt = 0; rd_cd = 0; rv_model = 1'b0; ready_r = 1'b0; prev_pend = 0;
    end else begin
      rv_model = 1'b0;
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          rv_model = 1'b1;
          rd_model = (rd_addr == 4'h4) ? tmr_lo : tmr_hi;
        end
      end
      if (prev_pend && (!iob.avalid || iob.addr !== p_addr ||
                        iob.wdata !== p_wdata || iob.wstrb !== p_wstrb))
        viol++;
      ready_r = 1'b0;
      prev_pend = 0;
      if (iob.avalid) begin
        if (iob.wstrb !== 4'h0 && iob.wstrb !== 4'hF) viol++;
        if (wait_cnt >= cfg_stall) begin
          ready_r  = 1'b1;
          wait_cnt = 0;
          log_q.push_back({iob.wstrb != 4'h0, iob.addr,
                           (iob.wstrb != 4'h0) ? iob.wdata : 32'h0});
          if (iob.wstrb == 4'h0) begin
            rd_cd   = cfg_d;
            rd_addr = iob.addr;
          end
        end else begin
          wait_cnt++;
          prev_pend = 1;
          p_addr = iob.addr; p_wdata = iob.wdata; p_wstrb = iob.wstrb;
        end
      end
    end
    if (ts_valid) tv_cnt++;
    if (err) err_cnt++;
  end

  // Reference: bus order is fixed; latency is the 7-cycle minimum plus one
  // cycle per ready stall on each of 4 requests and per extra rvalid delay on 2 reads.
  function automatic int model_lat(input int stall, input int d, input int frz);
    return 7 + 4 * stall + 2 * (d - 1) + frz;
  endfunction

  task automatic run_capture(input int stall, input int d, input int frz, input bit spur,
                             input logic [31:0] lo, input logic [31:0] hi,
                             input int exp_lat, input logic [63:0] exp_ts, input string tag);
    int lat;
    logic [36:0] exp_log[4];
    exp_log[0] = {1'b1, 4'h2, 32'd1};
    exp_log[1] = {1'b1, 4'h2, 32'd0};
    exp_log[2] = {1'b0, 4'h4, 32'd0};
    exp_log[3] = {1'b0, 4'h8, 32'd0};
    cfg_stall = stall; cfg_d = d; tmr_lo = lo; tmr_hi = hi;
    log_q.delete(); viol = 0;
    start = 1'b1;
    cke   = (frz == 0);
    if (spur) begin
      inj_data  = 32'hDEAD_BEEF;
      rv_inject = 1'b1;
    end
    lat = 0;
    while (lat < 400) begin
      @(negedge clk); #1;
      lat++;
      if (frz > 0 && lat == frz) begin
        chk({tag, " frozen_busy"}, busy, 0);
        cke = 1'b1;
      end
      if (lat == frz + 1) start = 1'b0;
      if (lat == 2) rv_inject = 1'b0;
      if (ts_valid) break;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " ts"}, ts, exp_ts);
    @(negedge clk); #1;
    chk({tag, " ts_valid_width"}, ts_valid, 0);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " xfer_count"}, log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("%s xfer%0d", tag, i), log_q[i], exp_log[i]);
    chk({tag, " bus_hold"}, viol, 0);
  endtask

  typedef struct {
    int          stall;
    int          d;
    int          frz;
    bit          spur;
    logic [31:0] lo;
    logic [31:0] hi;
    int          exp_lat;
    logic [63:0] exp_ts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, np, tv0, ev0;
    int pulses[8];
    logic [63:0] ts_before;
    logic [31:0] rlo, rhi;
    int rs, rd;

    vecs[0] = '{0, 1, 0, 0, 32'h1234_5678, 32'h0000_00AB, 7,  64'h0000_00AB_1234_5678};
    vecs[1] = '{3, 1, 0, 0, 32'hCAFE_F00D, 32'h0000_0001, 19, 64'h0000_0001_CAFE_F00D};
    vecs[2] = '{1, 2, 0, 0, 32'h89AB_CDEF, 32'h0123_4567, 13, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{0, 3, 0, 1, 32'h0BAD_F00D, 32'h00C0_FFEE, 11, 64'h00C0_FFEE_0BAD_F00D};
    vecs[4] = '{2, 1, 2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 7,  64'h0};

    arst_n = 1'b0; cke = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst ts_valid", ts_valid, 0);
    chk("rst ts", ts, 0);
    chk("rst err", err, 0);
    chk("rst avalid", iob.avalid, 0);
    chk("rst addr", iob.addr, 0);
    chk("rst wdata", iob.wdata, 0);
    chk("rst wstrb", iob.wstrb, 0);
    arst_n = 1'b1;
    @(negedge clk); #1;

    foreach (vecs[i])
      run_capture(vecs[i].stall, vecs[i].d, vecs[i].frz, vecs[i].spur, vecs[i].lo,
                  vecs[i].hi, vecs[i].exp_lat, vecs[i].exp_ts, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rs = $urandom_range(0, 3); rd = $urandom_range(1, 4);
      rlo = $urandom; rhi = $urandom;
      run_capture(rs, rd, 0, 0, rlo, rhi, model_lat(rs, rd, 0), {rhi, rlo},
                  $sformatf("rnd%0d", i));
    end

    // start held high: captures chain with the second start taken on the ts_valid cycle
    cfg_stall = 0; cfg_d = 1; tmr_lo = 32'h5555_AAAA; tmr_hi = 32'h0000_0F0F;
    log_q.delete(); viol = 0; np = 0;
    start = 1'b1; k = 0;
    while (k < 40) begin
      @(negedge clk); #1;
      k++;
      if (k == 20) start = 1'b0;
      if (ts_valid) begin
        if (np < 8) pulses[np] = k;
        np++;
      end
    end
    chk("b2b pulses", np, 3);
    chk("b2b pulse0", pulses[0], 7);
    chk("b2b pulse1", pulses[1], 14);
    chk("b2b pulse2", pulses[2], 21);
    chk("b2b xfers", log_q.size(), 12);
    chk("b2b ts", ts, 64'h0000_0F0F_5555_AAAA);
    chk("b2b bus_hold", viol, 0);

    // reset while a request is stalled: avalid must fall immediately
    cfg_stall = 3; cfg_d = 1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("rstreq avalid_before", iob.avalid, 1);
    arst_n = 1'b0; #1;
    chk("rstreq avalid", iob.avalid, 0);
    chk("rstreq busy", busy, 0);
    @(negedge clk); #1;
    arst_n = 1'b1;

    // reset in RHI_WAIT, then a late rvalid
    cfg_stall = 0; cfg_d = 4; tmr_lo = 32'h1111_2222; tmr_hi = 32'h3333_4444;
    log_q.delete();
    start = 1'b1; k = 0;
    while (log_q.size() < 4 && k < 50) begin
      @(negedge clk); #1;
      k++;
      start = 1'b0;
    end
    chk("rstwait reach", log_q.size(), 4);
    @(negedge clk); #1;
    chk("rstwait busy_before", busy, 1);
    tv0 = tv_cnt;
    arst_n = 1'b0; #1;
    chk("rstwait avalid", iob.avalid, 0);
    chk("rstwait ts", ts, 0);
    @(negedge clk); #1;
    arst_n = 1'b1;
    inj_data = 32'h3333_4444; rv_inject = 1'b1;
    @(negedge clk); #1;
    rv_inject = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstwait no_valid", tv_cnt, tv0);
    chk("rstwait ts_after", ts, 0);
    chk("rstwait busy_after", busy, 0);
    run_capture(0, 1, 0, 0, 32'h7777_8888, 32'h0000_0099, 7, 64'h0000_0099_7777_8888,
                "after_rst");

`ifdef IOB_TIMER_READER_TIMEOUT_EN
    cfg_stall = 0; cfg_d = 0;
    log_q.delete();
    ts_before = ts; ev0 = err_cnt; tv0 = tv_cnt;
    start = 1'b1; k = 0;
    while (log_q.size() < 3 && k < 50) begin
      @(negedge clk); #1;
      k++;
      start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk); #1;
    k = 0;
    while (!err && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("tmo delay", k, 8);
    @(negedge clk); #1;
    chk("tmo busy", busy, 0);
    chk("tmo err_width", err, 0);
    chk("tmo ts", ts, ts_before);
    chk("tmo no_valid", tv_cnt, tv0);
    chk("tmo err_pulses", err_cnt, ev0 + 1);
    cfg_d = 1;
    run_capture(1, 2, 0, 0, 32'hABCD_0123, 32'h0000_4567, 13, 64'h0000_4567_ABCD_0123,
                "after_tmo");
`else
    ts_before = '0; ev0 = 0;
    chk("no_err", err_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
